enigma_char_scheduler: RTL

- Sequences and shares the Enigma cipher core between two character requesters: A (UART host path) and B (local/direct path).
- Serialises one character at a time: accept, pulse the core, wait a fixed latency, capture the result, return it through a response handshake.
- Services key-configuration load requests only between characters, so rotor state never changes mid-encipherment.
- Sits between the top-level FSM/register file and the cipher core.

---
 rtl/enigma_char_scheduler_if.sv | 36 +++
 rtl/enigma_char_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/enigma_char_scheduler_if.sv
// Bundle of requester, key-load, cipher-core and response signals around the
// Enigma character scheduler. The slave side is the scheduler itself.
interface enigma_char_scheduler_if #(
  parameter int CHAR_W = 5
);
  logic              a_valid;
  logic [CHAR_W-1:0] a_char;
  logic              a_ready;
  logic              b_valid;
  logic [CHAR_W-1:0] b_char;
  logic              b_ready;
  logic              cfg_load_req;
  logic              cfg_load_ack;
  logic [CHAR_W-1:0] core_char_in;
  logic              core_new_char;
  logic              core_load_key;
  logic [CHAR_W-1:0] core_char_out;
  logic              rsp_valid;
  logic [CHAR_W-1:0] rsp_char;
  logic              rsp_src;
  logic              rsp_ready;
  logic              err_pulse;
  logic              busy;

  modport slave (
    input  a_valid, a_char, b_valid, b_char, cfg_load_req, core_char_out, rsp_ready,
    output a_ready, b_ready, cfg_load_ack, core_char_in, core_new_char, core_load_key,
           rsp_valid, rsp_char, rsp_src, err_pulse, busy
  );

  modport master (
    output a_valid, a_char, b_valid, b_char, cfg_load_req, core_char_out, rsp_ready,
    input  a_ready, b_ready, cfg_load_ack, core_char_in, core_new_char, core_load_key,
           rsp_valid, rsp_char, rsp_src, err_pulse, busy
  );
endinterface

// File: rtl/enigma_char_scheduler.sv
// Shares one Enigma cipher core between two character requesters, one character
// at a time, and applies key loads only between characters.
module enigma_char_scheduler #(
  parameter int CORE_LATENCY = 2,
  parameter int CHAR_W       = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  enigma_char_scheduler_if.slave  bus
);

  localparam int                CNT_W     = 4;
  localparam logic [CHAR_W-1:0] LAST_CODE = CHAR_W'(25);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q;
  logic               prio_b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CHAR_W-1:0]  core_char_in_q;
  logic               core_new_char_q;
  logic               core_load_key_q;
  logic               cfg_load_ack_q;
  logic               rsp_valid_q;
  logic [CHAR_W-1:0]  rsp_char_q;
  logic               rsp_src_q;
  logic               err_pulse_q;

  logic               grant_a;
  logic               grant_b;
  logic [CHAR_W-1:0]  sel_char;

  // A pending key load blocks grants so it always wins a tie with a character.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE && !bus.cfg_load_req) begin
      if (bus.a_valid && bus.b_valid) begin
        if (prio_b_q) grant_b = 1'b1;
        else          grant_a = 1'b1;
      end else if (bus.a_valid) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign sel_char = grant_b ? bus.b_char : bus.a_char;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      prio_b_q        <= 1'b0;
      cnt_q           <= '0;
      core_char_in_q  <= '0;
      core_new_char_q <= 1'b0;
      core_load_key_q <= 1'b0;
      cfg_load_ack_q  <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_char_q      <= '0;
      rsp_src_q       <= 1'b0;
      err_pulse_q     <= 1'b0;
    end else begin
      core_new_char_q <= 1'b0;
      core_load_key_q <= 1'b0;
      cfg_load_ack_q  <= 1'b0;
      err_pulse_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_load_req) begin
            state_q         <= S_LOAD;
            core_load_key_q <= 1'b1;
            cfg_load_ack_q  <= 1'b1;
          end else if (grant_a || grant_b) begin
            core_char_in_q <= sel_char;
            rsp_src_q      <= grant_b;
            prio_b_q       <= grant_a;
            // Out-of-range codes never reach the core, so rotors do not step.
            if (sel_char > LAST_CODE) begin
              err_pulse_q <= 1'b1;
            end else begin
              state_q         <= S_ISSUE;
              core_new_char_q <= 1'b1;
            end
          end
        end
        S_LOAD: state_q <= S_IDLE;
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_W'(CORE_LATENCY - 1);
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_char_q  <= bus.core_char_out;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.a_ready       = grant_a;
  assign bus.b_ready       = grant_b;
  assign bus.cfg_load_ack  = cfg_load_ack_q;
  assign bus.core_char_in  = core_char_in_q;
  assign bus.core_new_char = core_new_char_q;
  assign bus.core_load_key = core_load_key_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_char      = rsp_char_q;
  assign bus.rsp_src       = rsp_src_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule
